// File: rtl/local_inject_arbiter.sv
// local_inject_arbiter
// Shares one router Local input port among NUM_REQ packet generators.
// Generators are served round-robin. The winning flit is buffered and then
// replayed toward the router with a request/grant handshake. Forwarded packets
// are counted.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   PacketIn   in   flattened generator packets, generator i at [i*dataWidth +: dataWidth]
//   ReqUpStr   in   per-generator request, held with its packet until granted
//   GntUpStr   out  per-generator one-cycle grant pulse (one-hot or zero)
//   UpStrFull  out  backpressure to generators (registered copy of DnStrFull)
//   PacketOut  out  flit toward the router Local input
//   ReqDnStr   out  request to the router Local input
//   GntDnStr   in   router acceptance
//   DnStrFull  in   router Local input buffer full
//   PktCount   out  packets accepted by the router, wraps modulo 2^32
module local_inject_arbiter #(
    parameter logic [5:0]  routerID  = 6'b000_000,
    parameter int unsigned dataWidth = 32,
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned PTR_W     = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ*dataWidth-1:0] PacketIn,
    input  logic [NUM_REQ-1:0]           ReqUpStr,
    output logic [NUM_REQ-1:0]           GntUpStr,
    output logic [NUM_REQ-1:0]           UpStrFull,
    output logic [dataWidth-1:0]         PacketOut,
    output logic                         ReqDnStr,
    input  logic                         GntDnStr,
    input  logic                         DnStrFull,
    output logic [31:0]                  PktCount
);

    localparam int unsigned CNT_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACK     = 2'd1,
        WAIT_DN = 2'd2
    } stateType;

    stateType             state, stateNext;
    logic [PTR_W-1:0]     ptr, ptrNext;
    logic [PTR_W-1:0]     winner, winnerNext;
    logic [dataWidth-1:0] bufReg, bufNext;
    logic [NUM_REQ-1:0]   gntNext;
    logic [NUM_REQ-1:0]   fullNext;
    logic [dataWidth-1:0] pktOutNext;
    logic                 reqDnNext;
    logic [CNT_W-1:0]     cntNext;

    // routerID is informational only
    logic unusedRouterId;
    assign unusedRouterId = ^routerID;

    // Round-robin pick: prefer requesters at or above ptr, else wrap to the lowest.
    logic [NUM_REQ-1:0]              atOrAbovePtr;
    logic [NUM_REQ-1:0]              reqHigh;
    logic [NUM_REQ-1:0]              reqPick;
    logic [NUM_REQ-1:0]              pickOneHot;
    logic [PTR_W-1:0]                pickIdx;
    logic [PTR_W-1:0][NUM_REQ-1:0]   idxTerm;
    logic [dataWidth-1:0]            pktArr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : gSlice
        assign atOrAbovePtr[g] = (PTR_W'(g) >= ptr);
        assign pktArr[g]       = PacketIn[g*dataWidth +: dataWidth];
    end

    assign reqHigh    = ReqUpStr & atOrAbovePtr;
    assign reqPick    = (|reqHigh) ? reqHigh : ReqUpStr;
    // Isolate the lowest set bit of the candidate set
    assign pickOneHot = reqPick & (~reqPick + NUM_REQ'(1));

    // One-hot to binary: index bit b collects every position whose index has bit b set
    for (genvar b = 0; b < PTR_W; b++) begin : gIdxBit
        for (genvar g = 0; g < NUM_REQ; g++) begin : gIdxTerm
            assign idxTerm[b][g] = pickOneHot[g] & 1'(g >> b);
        end
        assign pickIdx[b] = |idxTerm[b];
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            winner    <= '0;
            bufReg    <= '0;
            GntUpStr  <= '0;
            UpStrFull <= '0;
            PacketOut <= '0;
            ReqDnStr  <= 1'b0;
            PktCount  <= '0;
        end else begin
            state     <= stateNext;
            ptr       <= ptrNext;
            winner    <= winnerNext;
            bufReg    <= bufNext;
            GntUpStr  <= gntNext;
            UpStrFull <= fullNext;
            PacketOut <= pktOutNext;
            ReqDnStr  <= reqDnNext;
            PktCount  <= cntNext;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        stateNext  = state;
        ptrNext    = ptr;
        winnerNext = winner;
        bufNext    = bufReg;
        gntNext    = '0;
        fullNext   = {NUM_REQ{DnStrFull}};
        pktOutNext = PacketOut;
        reqDnNext  = ReqDnStr;
        cntNext    = PktCount;

        case (state)
            IDLE: begin
                if (!DnStrFull && (|ReqUpStr)) begin
                    bufNext    = pktArr[pickIdx];
                    gntNext    = pickOneHot;
                    winnerNext = pickIdx;
                    stateNext  = ACK;
                end
            end
            ACK: begin
                pktOutNext = bufReg;
                reqDnNext  = 1'b1;
                stateNext  = WAIT_DN;
            end
            WAIT_DN: begin
                // DnStrFull is deliberately ignored here: the request stays up until granted
                if (GntDnStr) begin
                    reqDnNext = 1'b0;
                    cntNext   = PktCount + CNT_W'(1);
                    ptrNext   = (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + PTR_W'(1);
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

endmodule

// File: tb/tb_local_inject_arbiter.sv
// Testbench for local_inject_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level round-robin model.
module tb_local_inject_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic [N*DW-1:0] PacketIn;
    logic [N-1:0]    ReqUpStr;
    logic [N-1:0]    GntUpStr;
    logic [N-1:0]    UpStrFull;
    logic [DW-1:0]   PacketOut;
    logic            ReqDnStr;
    logic            GntDnStr;
    logic            DnStrFull;
    logic [31:0]     PktCount;

    int checks = 0;
    int errors = 0;

    // Model: one in-flight transaction record plus the expected visible outputs
    bit            mBusy = 1'b0;
    int            mAge  = 0;
    int            mWin  = 0;
    int            mPtr  = 0;
    logic [DW-1:0] mData = '0;
    logic [N-1:0]  eGnt  = '0;
    logic [N-1:0]  eUsf  = '0;
    logic          eReq  = 1'b0;
    logic [DW-1:0] eOut  = '0;
    logic [31:0]   eCnt  = '0;

    always #5 clk = ~clk;

    local_inject_arbiter #(
        .routerID (6'b000_000),
        .dataWidth(DW),
        .NUM_REQ  (N),
        .PTR_W    (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .PacketIn (PacketIn),
        .ReqUpStr (ReqUpStr),
        .GntUpStr (GntUpStr),
        .UpStrFull(UpStrFull),
        .PacketOut(PacketOut),
        .ReqDnStr (ReqDnStr),
        .GntDnStr (GntDnStr),
        .DnStrFull(DnStrFull),
        .PktCount (PktCount)
    );

    task automatic setSlice(input int i, input logic [DW-1:0] v);
        PacketIn[i*DW +: DW] = v;
    endtask

    // Advance one clock edge, update the model from the inputs seen at that edge,
    // and return #1 after the edge so outputs can be sampled.
    task automatic tick();
        logic [N-1:0]    req;
        logic [N*DW-1:0] pin;
        logic            full, gdn, rst;
        bit              found;
        int              c, w;
        req  = ReqUpStr;
        pin  = PacketIn;
        full = DnStrFull;
        gdn  = GntDnStr;
        rst  = reset;
        @(posedge clk);
        if (rst) begin
            mBusy = 1'b0; mPtr = 0;
            eGnt = '0; eUsf = '0; eReq = 1'b0; eOut = '0; eCnt = '0;
        end else begin
            eUsf = full ? {N{1'b1}} : '0;
            eGnt = '0;
            if (!mBusy) begin
                if (!full && req != '0) begin
                    found = 1'b0; w = 0;
                    for (int k = 0; k < N; k++) begin
                        c = (mPtr + k) % N;
                        if (!found && req[c]) begin found = 1'b1; w = c; end
                    end
                    mBusy = 1'b1; mAge = 0; mWin = w;
                    mData = DW'(pin >> (w * DW));
                    eGnt  = N'(1) << w;
                end
            end else if (mAge == 0) begin
                mAge = 1; eReq = 1'b1; eOut = mData;
            end else if (gdn) begin
                eReq  = 1'b0;
                eCnt  = eCnt + 32'd1;
                mPtr  = (mWin + 1) % N;
                mBusy = 1'b0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; ReqUpStr = '0; PacketIn = '0; GntDnStr = 1'b0; DnStrFull = 1'b1;
        tick(); tick();
        checks++;
        if (GntUpStr !== '0 || UpStrFull !== '0 || ReqDnStr !== 1'b0 || PacketOut !== '0 || PktCount !== '0) begin
            errors++;
            $display("FAIL reset_outputs gnt=%b usf=%b req=%b out=%h cnt=%0d expected all zero",
                     GntUpStr, UpStrFull, ReqDnStr, PacketOut, PktCount);
        end
        reset = 1'b0; DnStrFull = 1'b0;
    endtask

    task automatic test_single();
        setSlice(2, 32'hA5A5_0003); ReqUpStr = 4'b0100;
        tick();
        checks++;
        if (GntUpStr !== 4'b0100 || ReqDnStr !== 1'b0) begin
            errors++; $display("FAIL single_grant gnt=%b req=%b expected 0100/0", GntUpStr, ReqDnStr);
        end
        ReqUpStr = '0;
        tick();
        checks++;
        if (GntUpStr !== 4'b0000 || ReqDnStr !== 1'b1 || PacketOut !== 32'hA5A5_0003) begin
            errors++; $display("FAIL single_replay gnt=%b req=%b out=%h expected 0000/1/a5a50003",
                               GntUpStr, ReqDnStr, PacketOut);
        end
        GntDnStr = 1'b1;
        tick();
        GntDnStr = 1'b0;
        checks++;
        if (ReqDnStr !== 1'b0 || PktCount !== 32'd1) begin
            errors++; $display("FAIL single_done req=%b cnt=%0d expected 0/1", ReqDnStr, PktCount);
        end
    endtask

    // Pointer is 3 here: 3 beats 0, then the pointer wraps to 0
    task automatic test_wrap();
        setSlice(0, 32'h1111_0000); setSlice(3, 32'h3333_0003); ReqUpStr = 4'b1001;
        tick();
        checks++;
        if (GntUpStr !== 4'b1000) begin
            errors++; $display("FAIL wrap_first gnt=%b expected 1000", GntUpStr);
        end
        ReqUpStr = 4'b0001;
        tick();
        checks++;
        if (PacketOut !== 32'h3333_0003) begin
            errors++; $display("FAIL wrap_first_data out=%h expected 33330003", PacketOut);
        end
        GntDnStr = 1'b1; tick(); GntDnStr = 1'b0;
        tick();
        checks++;
        if (GntUpStr !== 4'b0001) begin
            errors++; $display("FAIL wrap_second gnt=%b expected 0001", GntUpStr);
        end
        ReqUpStr = '0;
        tick();
        checks++;
        if (PacketOut !== 32'h1111_0000) begin
            errors++; $display("FAIL wrap_second_data out=%h expected 11110000", PacketOut);
        end
        GntDnStr = 1'b1; tick(); GntDnStr = 1'b0;
        checks++;
        if (PktCount !== 32'd3) begin
            errors++; $display("FAIL wrap_count cnt=%0d expected 3", PktCount);
        end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] expGnt;
        int           win;
        reset = 1'b1; ReqUpStr = 4'b1111; GntDnStr = 1'b1;
        for (int i = 0; i < N; i++) setSlice(i, 32'hB0B0_0000 + DW'(i));
        tick();
        reset = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            tick();
            win    = ((c - 1) / 3) % N;
            expGnt = (c % 3 == 1) ? (N'(1) << win) : '0;
            checks++;
            if (GntUpStr !== expGnt) begin
                errors++; $display("FAIL b2b_grant cyc=%0d gnt=%b expected %b", c, GntUpStr, expGnt);
            end
            if (c % 3 == 2) begin
                checks++;
                if (PacketOut !== 32'hB0B0_0000 + DW'(win) || ReqDnStr !== 1'b1) begin
                    errors++; $display("FAIL b2b_data cyc=%0d out=%h req=%b expected %h/1",
                                       c, PacketOut, ReqDnStr, 32'hB0B0_0000 + DW'(win));
                end
            end
        end
        ReqUpStr = '0; GntDnStr = 1'b0;
        checks++;
        if (PktCount !== 32'd6) begin
            errors++; $display("FAIL b2b_count cnt=%0d expected 6", PktCount);
        end
    endtask

    task automatic test_backpressure();
        DnStrFull = 1'b1; setSlice(1, 32'hC1C1_0001); ReqUpStr = 4'b0010;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (UpStrFull !== 4'b1111 || GntUpStr !== 4'b0000) begin
                errors++; $display("FAIL full_hold cyc=%0d usf=%b gnt=%b expected 1111/0000",
                                   i, UpStrFull, GntUpStr);
            end
        end
        DnStrFull = 1'b0;
        tick();
        checks++;
        if (GntUpStr !== 4'b0010 || UpStrFull !== 4'b0000) begin
            errors++; $display("FAIL full_release gnt=%b usf=%b expected 0010/0000", GntUpStr, UpStrFull);
        end
        ReqUpStr = '0;
        tick();
        GntDnStr = 1'b1; tick(); GntDnStr = 1'b0;
        checks++;
        if (PktCount !== 32'd7) begin
            errors++; $display("FAIL full_count cnt=%0d expected 7", PktCount);
        end
    endtask

    task automatic test_delayed_gnt();
        logic [DW-1:0] data;
        data = $urandom;
        setSlice(0, data); ReqUpStr = 4'b0001;
        tick();
        checks++;
        if (GntUpStr !== 4'b0001) begin
            errors++; $display("FAIL delay_grant gnt=%b expected 0001", GntUpStr);
        end
        ReqUpStr = '0;
        tick();
        for (int i = 0; i < 5; i++) begin
            DnStrFull = (i % 2 == 0);
            tick();
            checks++;
            if (ReqDnStr !== 1'b1 || PacketOut !== data || PktCount !== 32'd7) begin
                errors++; $display("FAIL delay_hold cyc=%0d req=%b out=%h cnt=%0d expected 1/%h/7",
                                   i, ReqDnStr, PacketOut, PktCount, data);
            end
        end
        DnStrFull = 1'b0; GntDnStr = 1'b1;
        tick();
        GntDnStr = 1'b0;
        checks++;
        if (ReqDnStr !== 1'b0 || PktCount !== 32'd8) begin
            errors++; $display("FAIL delay_done req=%b cnt=%0d expected 0/8", ReqDnStr, PktCount);
        end
    endtask

    task automatic test_reset_abort();
        setSlice(3, 32'hD3D3_0003); ReqUpStr = 4'b1000;
        tick();
        checks++;
        if (GntUpStr !== 4'b1000) begin
            errors++; $display("FAIL abort_grant gnt=%b expected 1000", GntUpStr);
        end
        ReqUpStr = '0;
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (GntUpStr !== '0 || UpStrFull !== '0 || ReqDnStr !== 1'b0 || PacketOut !== '0 || PktCount !== '0) begin
            errors++; $display("FAIL abort_reset gnt=%b usf=%b req=%b out=%h cnt=%0d expected all zero",
                               GntUpStr, UpStrFull, ReqDnStr, PacketOut, PktCount);
        end
        GntDnStr = 1'b1;
        tick();
        GntDnStr = 1'b0;
        checks++;
        if (ReqDnStr !== 1'b0 || PktCount !== '0 || GntUpStr !== '0) begin
            errors++; $display("FAIL abort_stray_gnt req=%b cnt=%0d gnt=%b expected 0/0/0",
                               ReqDnStr, PktCount, GntUpStr);
        end
        // Pointer was 1 before reset; after reset generator 0 must beat generator 3
        setSlice(0, 32'hD0D0_0000); ReqUpStr = 4'b1001;
        tick();
        checks++;
        if (GntUpStr !== 4'b0001) begin
            errors++; $display("FAIL abort_ptr gnt=%b expected 0001", GntUpStr);
        end
        ReqUpStr = 4'b1000;
        tick();
        GntDnStr = 1'b1; tick(); GntDnStr = 1'b0;
        tick();
        checks++;
        if (GntUpStr !== 4'b1000) begin
            errors++; $display("FAIL abort_next gnt=%b expected 1000", GntUpStr);
        end
        ReqUpStr = '0;
        tick();
        GntDnStr = 1'b1; tick(); GntDnStr = 1'b0;
        checks++;
        if (PktCount !== 32'd2) begin
            errors++; $display("FAIL abort_count cnt=%0d expected 2", PktCount);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            ReqUpStr  = ReqUpStr & ~eGnt;
            for (int i = 0; i < N; i++) begin
                if (!ReqUpStr[i] && $urandom_range(0, 2) == 0) begin
                    setSlice(i, $urandom);
                    ReqUpStr[i] = 1'b1;
                end
            end
            DnStrFull = ($urandom_range(0, 4) == 0);
            GntDnStr  = 1'($urandom_range(0, 1));
            reset     = ($urandom_range(0, 199) == 0);
            tick();
            checks++;
            if (GntUpStr !== eGnt) begin
                errors++; $display("FAIL rand_gnt cyc=%0d got=%b exp=%b", c, GntUpStr, eGnt);
            end
            checks++;
            if (UpStrFull !== eUsf) begin
                errors++; $display("FAIL rand_usf cyc=%0d got=%b exp=%b", c, UpStrFull, eUsf);
            end
            checks++;
            if (ReqDnStr !== eReq) begin
                errors++; $display("FAIL rand_reqdn cyc=%0d got=%b exp=%b", c, ReqDnStr, eReq);
            end
            checks++;
            if (PacketOut !== eOut) begin
                errors++; $display("FAIL rand_pkt cyc=%0d got=%h exp=%h", c, PacketOut, eOut);
            end
            checks++;
            if (PktCount !== eCnt) begin
                errors++; $display("FAIL rand_cnt cyc=%0d got=%0d exp=%0d", c, PktCount, eCnt);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_back_to_back();
        test_backpressure();
        test_delayed_gnt();
        test_reset_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
